// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and defaults for the UART transmit path.
//   uart_tx_state_t   : TX sequencer FSM state encoding
//   UART_CLKS_PER_BIT : default baud divider (115200 baud @ 50 MHz)
//   UART_DATA_BITS    : default data bits per frame
//   frame_cycles()    : clock cycles spanned by one complete frame
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int UART_CLKS_PER_BIT = 434;
    localparam int UART_DATA_BITS    = 8;

    // Cycles from the first start-bit cycle to the end of the last stop bit.
    function automatic int frame_cycles(input int clks_per_bit,
                                        input int data_bits,
                                        input int stop_bits,
                                        input int parity_bits);
        return (1 + data_bits + parity_bits + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_sequencer_baud.sv
// ---------------------------------------------------------------------------
// baud_tick_counter
// Free-running modulo-MAX_COUNT counter that is held at zero while disabled.
// tick marks the last cycle of each bit period.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-low reset
//   enable in   count while high, clear to 0 while low
//   tick   out  count == MAX_COUNT-1
//   count  out  current count, 0..MAX_COUNT-1
// ---------------------------------------------------------------------------
module baud_tick_counter #(
    parameter int  MAX_COUNT = 434,
    localparam int CW        = $clog2(MAX_COUNT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          tick,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LAST = CW'(MAX_COUNT - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = '0;
        if (enable && count_q != LAST) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick  = (count_q == LAST);
    assign count = count_q;

endmodule

// File: rtl/uart_tx_sequencer.sv
// ---------------------------------------------------------------------------
// uart_tx_sequencer
// Frames one byte per valid/ready handshake and shifts it out LSB first as
// start, data, optional parity and stop bits. The baud counter only runs
// while a frame is in flight, so each frame is phase-aligned to its accept.
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit (even when
// PARITY_ODD=0, odd when PARITY_ODD=1) between the data and stop bits.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   tx_valid   in   producer has a byte on tx_data
//   tx_data    in   byte to send, sampled only on accept
//   tx_ready   out  sequencer idle; accept = tx_valid & tx_ready
//   tx_serial  out  registered UART line, idles high
//   tx_busy    out  frame in flight
//   tx_done    out  one-cycle pulse as the frame completes
// ---------------------------------------------------------------------------
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BW = $clog2(DATA_BITS);

    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_err
        $error("uart_tx_sequencer: parameter out of range");
    end

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_serial_q, tx_serial_d;
    logic                 tx_done_q, tx_done_d;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    // The shift register is consumed by the data bits, so parity is
    // captured from the byte at accept time.
    logic                 parity_q, parity_d;
`endif

    baud_tick_counter #(
        .MAX_COUNT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q != IDLE),
        .tick   (tick),
        .count  ()
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d    = START;
                    shift_d    = tx_data;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d   = (^tx_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d    = IDLE;
                        stop_cnt_d = 1'b0;
                        tx_done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line value follows the current state one cycle later, which keeps the
    // pin driven straight from a flop.
    always_comb begin
        tx_serial_d = 1'b1;
        case (state_q)
            START:   tx_serial_d = 1'b0;
            DATA:    tx_serial_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_serial_d = parity_q;
`endif
            default: tx_serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            tx_serial_q <= 1'b1;
            tx_done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            tx_serial_q <= tx_serial_d;
            tx_done_q   <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign tx_ready  = (state_q == IDLE);
    assign tx_busy   = (state_q != IDLE);
    assign tx_serial = tx_serial_q;
    assign tx_done   = tx_done_q;

endmodule
